// File: rtl/game_pkg.sv
// Shared types for the snake game-flow controller: state encoding and sizing helpers.
package game_pkg;

    localparam logic [2:0] CODE_IDLE      = 3'd0;
    localparam logic [2:0] CODE_PLAYING   = 3'd1;
    localparam logic [2:0] CODE_PAUSED    = 3'd2;
    localparam logic [2:0] CODE_DYING     = 3'd3;
    localparam logic [2:0] CODE_GAME_OVER = 3'd4;
    localparam logic [2:0] CODE_WIN       = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = CODE_IDLE,
        ST_PLAYING   = CODE_PLAYING,
        ST_PAUSED    = CODE_PAUSED,
        ST_DYING     = CODE_DYING,
        ST_GAME_OVER = CODE_GAME_OVER,
        ST_WIN       = CODE_WIN
    } state_t;

    function automatic int lives_w(input int num_lives);
        return $clog2(num_lives + 1);
    endfunction

endpackage

// File: rtl/respawn_timer.sv
// Loadable down-counter advanced by a tick enable; done flags the tick that takes it from 1 to 0.
// Load has priority over ticking; the counter saturates at zero.
module respawn_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick_en,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick_en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = tick_en && !load && (count_q == W'(1));

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow controller: lives, respawn delay, pause/resume and win detection for the snake engine.
// All flags are Moore decodes of the state register; respawn is a registered one-cycle pulse.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int NUM_LIVES     = 3,
    parameter int RESPAWN_TICKS = 8,
    parameter int SCORE_W       = 8,
    parameter int WIN_SCORE     = 100,
    localparam int LIVES_W      = lives_w(NUM_LIVES)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pause_toggle,
    input  logic               collision,
    input  logic               tick,
    input  logic [SCORE_W-1:0] score,
    output logic               running,
    output logic               paused,
    output logic               gameOver,
    output logic               gameWin,
    output logic [LIVES_W-1:0] lives_left,
    output logic               respawn,
    output logic [2:0]         state_code
);

    localparam int                 CNT_W       = $clog2(RESPAWN_TICKS + 1);
    localparam logic [CNT_W-1:0]   RESPAWN_VAL = CNT_W'(RESPAWN_TICKS);
    localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(NUM_LIVES);
    localparam logic [SCORE_W-1:0] WIN_VAL     = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               respawn_q, respawn_d;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_done;
    logic               fresh_game;

    respawn_timer #(
        .W (CNT_W)
    ) u_respawn_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick_en  (tick && (state_q == ST_DYING)),
        .done     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        respawn_d  = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = RESPAWN_VAL;
        fresh_game = 1'b0;

        case (state_q)
            ST_IDLE: begin
                lives_d    = LIVES_INIT;
                fresh_game = start;
            end
            ST_PLAYING: begin
                // Collision outranks win and pause; a simultaneous pause is dropped.
                if (collision && (lives_q == LIVES_W'(1))) begin
                    state_d = ST_GAME_OVER;
                    lives_d = '0;
                end else if (collision) begin
                    state_d  = ST_DYING;
                    lives_d  = lives_q - LIVES_W'(1);
                    tmr_load = 1'b1;
                end else if (score >= WIN_VAL) begin
                    state_d = ST_WIN;
                end else if (pause_toggle) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (start) begin
                    fresh_game = 1'b1;
                end else if (pause_toggle) begin
                    state_d = ST_PLAYING;
                end
            end
            ST_DYING: begin
                if (start) begin
                    // Abandon the pending delay so a later death starts from a clean count.
                    fresh_game = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = '0;
                end else if (tmr_done) begin
                    state_d   = ST_PLAYING;
                    respawn_d = 1'b1;
                end
            end
            ST_GAME_OVER, ST_WIN: begin
                fresh_game = start;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fresh_game) begin
            state_d   = ST_PLAYING;
            lives_d   = LIVES_INIT;
            respawn_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= LIVES_INIT;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            respawn_q <= respawn_d;
        end
    end

    assign running    = (state_q == ST_PLAYING);
    assign paused     = (state_q == ST_PAUSED);
    assign gameOver   = (state_q == ST_GAME_OVER);
    assign gameWin    = (state_q == ST_WIN);
    assign lives_left = lives_q;
    assign respawn    = respawn_q;
    assign state_code = state_q;

endmodule
